wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning per-channel FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports alu_valid in 1, alu_rd in 5, alu_data in 64, alu_ready out 1: ALU result channel, valid/ready.
REQ-005 SHALL have ports mem_valid in 1, mem_rd in 5, mem_data in 64, mem_ready out 1: load-result channel, valid/ready.
REQ-006 SHALL have ports iss_valid in 1, iss_rd in 5: dispatch notice that a producer of rd is in flight.
REQ-007 SHALL have ports we3 out 1, wa3 out 5, wd3 out 64: register-file write port drive.
REQ-008 SHALL have port busy out 32: per-register pending-write scoreboard.

Function
REQ-009 SHALL accept a channel transfer at a rising edge where valid and ready are both 1; ready SHALL be 1 iff that channel's FIFO is not full, independent of valid.
REQ-010 SHALL hold each accepted {rd, data} in a per-channel FIFO in arrival order; data SHALL not change while queued.
REQ-011 SHALL grant at most one FIFO head per cycle: only one non-empty -> that one; both non-empty -> round-robin, the channel not granted last wins; after reset MEM wins first tie.
REQ-012 SHALL pop the granted head and load we3/wa3/wd3 registers at the same edge; we3=1 for exactly one cycle per popped entry with rd!=31.
REQ-013 SHALL pop rd=31 entries normally but drive we3=0 that cycle (XZR writes discarded); wa3/wd3 still SHALL load the entry values.
REQ-014 SHALL drive we3=0 in any cycle following an edge with no grant; wa3/wd3 SHALL hold their previous values.
REQ-015 SHALL have minimum latency of one cycle: transfer at edge t into an empty FIFO -> we3=1 during the cycle after edge t+1 (no same-edge FIFO bypass).
REQ-016 SHALL allow push and pop on a full FIFO at the same edge only in the order pop-then-push is not permitted: ready reflects pre-edge occupancy, so a full FIFO refuses input even when popping.
REQ-017 SHALL wrap FIFO read/write pointers modulo DEPTH, with one extra bit to distinguish full from empty.
REQ-018 SHALL set busy[iss_rd] at an edge with iss_valid=1 and iss_rd!=31.
REQ-019 SHALL clear busy[wa3_next] at the edge that loads a we3=1 write.
REQ-020 SHALL let set win over clear when both target the same register at the same edge.
REQ-021 SHALL hold busy[31]=0 always.

Reset
REQ-022 SHALL on reset=0, immediately and regardless of clk: empty both FIFOs, we3=0, wa3=0, wd3=0, busy=0, round-robin pointer to MEM-first, alu_ready=mem_ready=1 once reset=1.
REQ-023 SHALL discard queued entries and pending busy bits on reset mid-operation; no write SHALL issue in the first cycle after reset deasserts.

Structure
REQ-024 SHALL place in shared package wb_pkg: wb_entry_t (rd 5, data 64), constant XZR=5'd31, constant WB_DEPTH_DEFAULT=2.
REQ-025 SHALL implement each channel queue as sub-module wb_fifo (parameter DEPTH, element wb_entry_t), instantiated twice.

Verification
REQ-026 Single ALU transfer rd=5, data=64'hDEAD at edge t -> we3=1, wa3=5, wd3=64'hDEAD in cycle after edge t+1, we3=0 next cycle.
REQ-027 Both channels push every cycle (ALU rd=1..4, MEM rd=11..14) -> writes alternate MEM,ALU,MEM,ALU,...; each channel's order preserved; ready drops to 0 when FIFO holds 2.
REQ-028 MEM transfer rd=31 data=64'h1 -> entry popped, we3 stays 0, busy unchanged.
REQ-029 iss_valid with iss_rd=7, later ALU write rd=7 -> busy[7]=1 until the write edge, 0 after; iss_rd=7 again on the write edge -> busy[7] stays 1.
REQ-030 Fill both FIFOs, assert reset=0 mid-cycle -> we3=0 and busy=0 immediately; after release, no we3 pulse and both ready=1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its channel FIFOs.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  localparam logic [4:0] XZR = 5'd31;
  localparam int WB_DEPTH_DEFAULT = 2;

  // Round-robin state names the channel that wins the next tie.
  typedef enum logic {
    RR_MEM_FIRST = 1'b0,
    RR_ALU_FIRST = 1'b1
  } rr_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_MEM  = 2'd2
  } grant_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the ALU/load producers, the dispatch stage and the writeback arbiter.
interface wb_arbiter_if;

  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;

  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic        mem_ready;

  logic        iss_valid;
  logic [4:0]  iss_rd;

  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [31:0] busy;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  iss_valid, iss_rd,
    output alu_ready, mem_ready,
    output we3, wa3, wd3, busy
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output iss_valid, iss_rd,
    input  alu_ready, mem_ready,
    input  we3, wa3, wd3, busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Per-channel FIFO of writeback entries; ready depends only on pre-edge occupancy.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  wb_entry_t i_data,
  output logic      o_ready,
  input  logic      i_pop,
  output logic      o_empty,
  output wb_entry_t o_head
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_full;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_ready   = !w_full;
  assign w_do_push = i_push && !w_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load results onto the single register-file write port and
// tracks in-flight destination registers in a busy scoreboard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  wb_entry_t   w_alu_in;
  wb_entry_t   w_mem_in;
  wb_entry_t   w_alu_head;
  wb_entry_t   w_mem_head;
  wb_entry_t   w_sel;
  logic        w_alu_empty;
  logic        w_mem_empty;
  logic        w_alu_ready;
  logic        w_mem_ready;
  logic        w_we3_next;
  grant_t      w_grant;
  rr_state_t   r_rr_state;
  rr_state_t   w_rr_next;
  logic        r_we3;
  logic [4:0]  r_wa3;
  logic [63:0] r_wd3;
  logic [30:0] w_busy;

  assign w_alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
  assign w_mem_in = '{rd: bus.mem_rd, data: bus.mem_data};

  wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.alu_valid),
    .i_data  (w_alu_in),
    .o_ready (w_alu_ready),
    .i_pop   (w_grant == GNT_ALU),
    .o_empty (w_alu_empty),
    .o_head  (w_alu_head)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_mem_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.mem_valid),
    .i_data  (w_mem_in),
    .o_ready (w_mem_ready),
    .i_pop   (w_grant == GNT_MEM),
    .o_empty (w_mem_empty),
    .o_head  (w_mem_head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rr_state <= RR_MEM_FIRST;
    else        r_rr_state <= w_rr_next;
  end

  // The channel just served loses the next tie.
  always_comb begin
    w_rr_next = r_rr_state;
    case (w_grant)
      GNT_ALU: w_rr_next = RR_MEM_FIRST;
      GNT_MEM: w_rr_next = RR_ALU_FIRST;
      default: w_rr_next = r_rr_state;
    endcase
  end

  always_comb begin
    w_grant = GNT_NONE;
    if (!w_alu_empty && !w_mem_empty) begin
      w_grant = (r_rr_state == RR_ALU_FIRST) ? GNT_ALU : GNT_MEM;
    end else if (!w_alu_empty) begin
      w_grant = GNT_ALU;
    end else if (!w_mem_empty) begin
      w_grant = GNT_MEM;
    end
  end

  assign w_sel      = (w_grant == GNT_ALU) ? w_alu_head : w_mem_head;
  assign w_we3_next = (w_grant != GNT_NONE) && (w_sel.rd != XZR);

  // XZR entries still load wa3/wd3 so the port shows what was discarded.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else begin
      r_we3 <= w_we3_next;
      if (w_grant != GNT_NONE) begin
        r_wa3 <= w_sel.rd;
        r_wd3 <= w_sel.data;
      end
    end
  end

  for (genvar gi = 0; gi < 31; gi++) begin : g_busy
    logic r_bit;
    logic w_set;
    logic w_clr;

    assign w_set = bus.iss_valid && (bus.iss_rd == 5'(gi));
    assign w_clr = w_we3_next && (w_sel.rd == 5'(gi));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_bit <= 1'b0;
      else if (w_set) r_bit <= 1'b1;
      else if (w_clr) r_bit <= 1'b0;
    end

    assign w_busy[gi] = r_bit;
  end

  assign bus.alu_ready = w_alu_ready;
  assign bus.mem_ready = w_mem_ready;
  assign bus.we3       = r_we3;
  assign bus.wa3       = r_wa3;
  assign bus.wd3       = r_wd3;
  assign bus.busy      = {1'b0, w_busy};

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed scoreboard bench for wb_arbiter: stimulus queues expected writes,
// a negedge monitor checks every we3 pulse against them.
module tb_wb_arbiter;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   sb_ignore;
  exp_t sb[$];

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input logic [4:0] rd, input logic [63:0] d, input int c);
    exp_t e;
    e.rd = rd;
    e.data = d;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every write pulse must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset && !sb_ignore && bus.we3) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got wa3=%0d wd3=%0h required no write", bus.wa3, bus.wd3);
      end else begin
        e = sb.pop_front();
        $display("write cyc=%0d wa3=%0d wd3=%0h", cyc, bus.wa3, bus.wd3);
        check("wr_rd", 64'(bus.wa3), 64'(e.rd));
        check("wr_data", bus.wd3, e.data);
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int c0;
    int ai;
    int mi;
    int it;
    bit acc_a;
    bit acc_m;
    logic [31:0] snap;

    n_checks = 0;
    n_fail = 0;
    sb_ignore = 1'b0;
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    check("rst_we3", 64'(bus.we3), 64'd0);
    check("rst_wa3", 64'(bus.wa3), 64'd0);
    check("rst_wd3", bus.wd3, 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);

    // Both channels stream four entries: MEM wins the first tie, then strict alternation.
    c0 = cyc;
    exp_push(5'd11, 64'hB00B, c0 + 2);
    exp_push(5'd1,  64'hA001, c0 + 3);
    exp_push(5'd12, 64'hB00C, c0 + 4);
    exp_push(5'd2,  64'hA002, c0 + 5);
    exp_push(5'd13, 64'hB00D, c0 + 6);
    exp_push(5'd3,  64'hA003, c0 + 7);
    exp_push(5'd14, 64'hB00E, c0 + 8);
    exp_push(5'd4,  64'hA004, c0 + 9);
    ai = 0; mi = 0; it = 0;
    while ((ai < 4 || mi < 4) && it < 40) begin
      if (it == 2) begin
        check("alu_ready_full", 64'(bus.alu_ready), 64'd0);
        check("mem_ready_notfull", 64'(bus.mem_ready), 64'd1);
      end
      if (it == 3) check("mem_ready_full", 64'(bus.mem_ready), 64'd0);
      bus.alu_valid = (ai < 4);
      bus.alu_rd    = 5'(ai + 1);
      bus.alu_data  = 64'hA000 + 64'(ai + 1);
      bus.mem_valid = (mi < 4);
      bus.mem_rd    = 5'(mi + 11);
      bus.mem_data  = 64'hB000 + 64'(mi + 11);
      acc_a = bus.alu_valid && bus.alu_ready;
      acc_m = bus.mem_valid && bus.mem_ready;
      @(negedge clk);
      if (acc_a) ai++;
      if (acc_m) mi++;
      it++;
    end
    if (it >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL stream_timeout: got %0d/%0d accepted required 4/4", ai, mi);
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Single ALU transfer: pulse appears one cycle after the accepting edge, for one cycle.
    c0 = cyc;
    exp_push(5'd5, 64'hDEAD, c0 + 2);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'hDEAD;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    @(negedge clk);
    check("single_we3", 64'(bus.we3), 64'd1);
    @(negedge clk);
    check("single_we3_drop", 64'(bus.we3), 64'd0);
    check("single_wa3_hold", 64'(bus.wa3), 64'd5);

    // XZR entry is popped with we3 low and busy untouched.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd31; bus.mem_data = 64'h1;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    snap = bus.busy;
    @(negedge clk);
    check("xzr_we3", 64'(bus.we3), 64'd0);
    check("xzr_wa3", 64'(bus.wa3), 64'd31);
    check("xzr_wd3", bus.wd3, 64'h1);
    check("xzr_busy", 64'(bus.busy), 64'(snap));
    check("xzr_busy9", 64'(bus.busy[9]), 64'd1);

    // busy[31] can never be set.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd31;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    @(negedge clk);
    check("busy31", 64'(bus.busy[31]), 64'd0);

    // Scoreboard set, hold, and clear on the write edge.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    check("busy7_set", 64'(bus.busy[7]), 64'd1);
    @(negedge clk);
    c0 = cyc;
    exp_push(5'd7, 64'h77, c0 + 2);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h77;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    check("busy7_pending", 64'(bus.busy[7]), 64'd1);
    @(negedge clk);
    check("busy7_cleared", 64'(bus.busy[7]), 64'd0);

    // Set on the same edge as the clearing write wins.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    c0 = cyc;
    exp_push(5'd7, 64'h78, c0 + 2);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 64'h78;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    @(negedge clk);
    bus.iss_valid = 1'b0;
    check("busy7_set_wins", 64'(bus.busy[7]), 64'd1);
    @(negedge clk);
    check("directed_drained", 64'(sb.size()), 64'd0);

    // Load both FIFOs and a busy bit, then reset in the middle of a cycle.
    sb_ignore = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 64'h20;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd21; bus.mem_data = 64'h21;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    @(negedge clk);
    bus.alu_rd = 5'd22; bus.alu_data = 64'h22;
    bus.mem_rd = 5'd23; bus.mem_data = 64'h23;
    bus.iss_valid = 1'b0;
    @(negedge clk);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    check("pre_rst_busy3", 64'(bus.busy[3]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_we3", 64'(bus.we3), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_wa3", 64'(bus.wa3), 64'd0);
    check("mid_rst_wd3", bus.wd3, 64'd0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb_ignore = 1'b0;
    check("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("post_rst_mem_ready", 64'(bus.mem_ready), 64'd1);
    @(negedge clk);
    check("post_rst_we3", 64'(bus.we3), 64'd0);
    repeat (4) @(negedge clk);
    check("post_rst_busy", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
